// File: rtl/ps2_receiver.sv
// ---------------------------------------------------------------------------
// ps2_receiver
//
// Receives PS/2 device-to-host frames from the raw keyboard pins. A frame is
// 11 bits: a start bit (0), 8 data bits sent LSB first, an odd parity bit and
// a stop bit (1). Each frame that passes both the parity and the stop-bit
// check is written to d_out, and tick pulses for one cycle. d_out feeds a
// downstream byte buffer's data input, and tick feeds that buffer's
// byte-count strobe.
//
// Parameters
//   FILTER_LEN      number of clk cycles ps2_clk must stay at one level
//                   before the new level is accepted (must be >= 2)
//   TIMEOUT_CYCLES  largest allowed number of clk cycles between accepted
//                   falling edges inside a frame
//
// Ports
//   clk         system clock; all state changes on its rising edge
//   reset       asynchronous reset, active low
//   ps2_clk     raw PS/2 clock pin (asynchronous, idles high)
//   ps2_data    raw PS/2 data pin (asynchronous, idles high)
//   d_out       last valid byte; holds its value until the next valid frame
//   tick        one-cycle pulse in the cycle d_out takes a new byte
//   parity_err  one-cycle pulse: a frame ended with bad odd parity
//   frame_err   one-cycle pulse: stop bit was 0, or inter-edge timeout
//   busy        high while a frame is being received
// ---------------------------------------------------------------------------
module ps2_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] d_out,
    output logic       tick,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Pin synchronizers. Bit 0 is ps2_clk and bit 1 is ps2_data. Both reset
    // to 1, the idle level of the bus, so leaving reset creates no edge.
    // -----------------------------------------------------------------------
    logic [1:0] pin_raw;
    logic [1:0] pin_sync;

    assign pin_raw = {ps2_data, ps2_clk};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic stable_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    meta_reg   <= 1'b1;
                    stable_reg <= 1'b1;
                end else begin
                    meta_reg   <= pin_raw[gi];
                    stable_reg <= meta_reg;
                end
            end

            assign pin_sync[gi] = stable_reg;
        end
    endgenerate

    logic clk_sync;
    logic data_sync;

    assign clk_sync  = pin_sync[0];
    assign data_sync = pin_sync[1];

    // -----------------------------------------------------------------------
    // Clock glitch filter. The filtered level changes only after the last
    // FILTER_LEN synchronized samples all agree. Any shorter pulse leaves
    // the filtered level unchanged.
    // -----------------------------------------------------------------------
    logic [FILTER_LEN-1:0] filter_reg;
    logic                  filt_clk_reg;
    logic                  filter_zero;
    logic                  filter_ones;
    logic                  fall;

    assign filter_zero = (filter_reg == '0);
    assign filter_ones = &filter_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filter_reg   <= '1;
            filt_clk_reg <= 1'b1;
        end else begin
            filter_reg <= {filter_reg[FILTER_LEN-2:0], clk_sync};
            if (filter_zero) begin
                filt_clk_reg <= 1'b0;
            end else if (filter_ones) begin
                filt_clk_reg <= 1'b1;
            end
        end
    end

    // fall is high in the cycle where the filtered clock is about to go from
    // 1 to 0. The FSM acts on this edge in the same cycle, so the outputs
    // are registered one cycle after the edge.
    assign fall = filt_clk_reg & filter_zero;

    // -----------------------------------------------------------------------
    // Frame FSM: state register
    // -----------------------------------------------------------------------
    state_t          state_reg,      state_next;
    logic [2:0]      bit_idx_reg,    bit_idx_next;
    logic [7:0]      shift_reg,      shift_next;
    logic            parity_reg,     parity_next;
    logic [TW-1:0]   timer_reg,      timer_next;
    logic [7:0]      d_out_reg,      d_out_next;
    logic            tick_reg,       tick_next;
    logic            parity_err_reg, parity_err_next;
    logic            frame_err_reg,  frame_err_next;
    logic            busy_reg,       busy_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            bit_idx_reg    <= 3'd0;
            shift_reg      <= 8'h00;
            parity_reg     <= 1'b0;
            timer_reg      <= '0;
            d_out_reg      <= 8'h00;
            tick_reg       <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bit_idx_reg    <= bit_idx_next;
            shift_reg      <= shift_next;
            parity_reg     <= parity_next;
            timer_reg      <= timer_next;
            d_out_reg      <= d_out_next;
            tick_reg       <= tick_next;
            parity_err_reg <= parity_err_next;
            frame_err_reg  <= frame_err_next;
            busy_reg       <= busy_next;
        end
    end

    // -----------------------------------------------------------------------
    // Frame FSM: next state and outputs
    // -----------------------------------------------------------------------
    logic parity_ok;

    // The data byte and the parity bit together must hold an odd number of ones.
    assign parity_ok = ^{shift_reg, parity_reg};

    always_comb begin
        state_next      = state_reg;
        bit_idx_next    = bit_idx_reg;
        shift_next      = shift_reg;
        parity_next     = parity_reg;
        d_out_next      = d_out_reg;
        tick_next       = 1'b0;
        parity_err_next = 1'b0;
        frame_err_next  = 1'b0;

        // The timer measures the gap since the last accepted edge. It stays
        // cleared while idle, so waiting between frames never times out.
        if (fall || (state_reg == IDLE)) begin
            timer_next = '0;
        end else begin
            timer_next = timer_reg + 1'b1;
        end

        case (state_reg)
            IDLE: begin
                // A falling edge with data high is noise or the tail of a
                // frame that was cut off. It is ignored without a flag.
                if (fall && !data_sync) begin
                    state_next   = DATA;
                    bit_idx_next = 3'd0;
                    shift_next   = 8'h00;
                end
            end

            DATA: begin
                if (fall) begin
                    shift_next[bit_idx_reg] = data_sync;
                    bit_idx_next            = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = PARITY;
                    end
                end
            end

            PARITY: begin
                if (fall) begin
                    parity_next = data_sync;
                    state_next  = STOP;
                end
            end

            STOP: begin
                if (fall) begin
                    state_next      = IDLE;
                    parity_err_next = !parity_ok;
                    frame_err_next  = !data_sync;
                    if (parity_ok && data_sync) begin
                        d_out_next = shift_reg;
                        tick_next  = 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort a stalled frame. A real edge in the same cycle wins, because
        // that edge is itself proof the device is still sending.
        if ((state_reg != IDLE) && !fall && (timer_reg == TIMEOUT_LAST)) begin
            state_next     = IDLE;
            frame_err_next = 1'b1;
            timer_next     = '0;
        end

        busy_next = (state_next != IDLE);
    end

    assign d_out      = d_out_reg;
    assign tick       = tick_reg;
    assign parity_err = parity_err_reg;
    assign frame_err  = frame_err_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_ps2_receiver.sv
// ---------------------------------------------------------------------------
// tb_ps2_receiver
//
// Directed testbench for ps2_receiver. It drives PS/2 frames bit by bit with
// a 200 ns half-period on a 100 MHz clk. A negedge monitor counts the cycles
// in which tick, parity_err and frame_err are high. It also counts any change
// to d_out outside a tick cycle. Each scenario task compares those counts,
// and the outputs, against hand-computed values.
// ---------------------------------------------------------------------------
module tb_ps2_receiver;

    localparam int FL = 8;
    localparam int TO = 1000;
    localparam int H  = 200;   // PS/2 half-period in ns (20 clk cycles)

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] d_out;
    logic       tick;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    int         tick_cnt  = 0;
    int         perr_cnt  = 0;
    int         ferr_cnt  = 0;
    int         dout_bad  = 0;
    logic [7:0] dout_prev = 8'h00;

    ps2_receiver #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .d_out     (d_out),
        .tick      (tick),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Each count goes up once for every cycle its signal is high. A count
    // that rises by exactly 1 therefore means one pulse, one cycle long.
    always @(negedge clk) begin
        if (tick === 1'b1)       tick_cnt <= tick_cnt + 1;
        if (parity_err === 1'b1) perr_cnt <= perr_cnt + 1;
        if (frame_err === 1'b1)  ferr_cnt <= ferr_cnt + 1;
        if (reset === 1'b1 && tick !== 1'b1 && d_out !== dout_prev)
            dout_bad <= dout_bad + 1;
        dout_prev <= d_out;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_bit(input logic b);
        ps2_data = b;
        #(H / 2);
        ps2_clk = 1'b0;
        #(H);
        ps2_clk = 1'b1;
        #(H / 2);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par,
                              input logic stp, input int glitch_after);
        @(negedge clk);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(b[i]);
            if (i == glitch_after) begin
                #50;
                ps2_clk = 1'b0;
                #30;
                ps2_clk = 1'b1;
                #50;
            end
        end
        send_bit(par);
        send_bit(stp);
        ps2_data = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        if (d_out !== 8'h00) begin failures++; $display("FAIL reset_d_out: got %h expected 00", d_out); end
        checks++;
        if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick: got %b expected 0", tick); end
        checks++;
        if (parity_err !== 1'b0 || frame_err !== 1'b0) begin
            failures++; $display("FAIL reset_errs: got perr=%b ferr=%b expected 0 0", parity_err, frame_err);
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        reset = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_valid_frame();
        int t0, p0, f0;
        t0 = tick_cnt; p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        if (tick_cnt - t0 !== 1) begin failures++; $display("FAIL valid_tick: got %0d expected 1", tick_cnt - t0); end
        checks++;
        if (d_out !== 8'h1C) begin failures++; $display("FAIL valid_d_out: got %h expected 1c", d_out); end
        checks++;
        if (perr_cnt - p0 !== 0 || ferr_cnt - f0 !== 0) begin
            failures++; $display("FAIL valid_errs: got perr=%0d ferr=%0d expected 0 0", perr_cnt - p0, ferr_cnt - f0);
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL valid_busy: got %b expected 0", busy); end
        checks++;
    endtask

    task automatic test_back_to_back();
        int t0;
        t0 = tick_cnt;
        send_frame(8'hF0, 1'b1, 1'b1, -1);
        if (d_out !== 8'hF0) begin failures++; $display("FAIL b2b_first: got %h expected f0", d_out); end
        checks++;
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        if (d_out !== 8'h1C) begin failures++; $display("FAIL b2b_second: got %h expected 1c", d_out); end
        checks++;
        if (tick_cnt - t0 !== 2) begin failures++; $display("FAIL b2b_ticks: got %0d expected 2", tick_cnt - t0); end
        checks++;
    endtask

    task automatic test_parity();
        int t0, p0, f0;
        send_frame(8'h5A, 1'b1, 1'b1, -1);
        if (d_out !== 8'h5A) begin failures++; $display("FAIL parity_prior: got %h expected 5a", d_out); end
        checks++;
        t0 = tick_cnt; p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, -1);
        if (perr_cnt - p0 !== 1) begin failures++; $display("FAIL parity_flag: got %0d expected 1", perr_cnt - p0); end
        checks++;
        if (tick_cnt - t0 !== 0 || ferr_cnt - f0 !== 0) begin
            failures++; $display("FAIL parity_other: got tick=%0d ferr=%0d expected 0 0", tick_cnt - t0, ferr_cnt - f0);
        end
        checks++;
        if (d_out !== 8'h5A) begin failures++; $display("FAIL parity_hold: got %h expected 5a", d_out); end
        checks++;
        // Bad parity and bad stop bit together: both flags must pulse.
        t0 = tick_cnt; p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'h1C, 1'b1, 1'b0, -1);
        if (perr_cnt - p0 !== 1 || ferr_cnt - f0 !== 1 || tick_cnt - t0 !== 0) begin
            failures++; $display("FAIL both_bad: got perr=%0d ferr=%0d tick=%0d expected 1 1 0",
                                 perr_cnt - p0, ferr_cnt - f0, tick_cnt - t0);
        end
        checks++;
        if (d_out !== 8'h5A) begin failures++; $display("FAIL both_bad_hold: got %h expected 5a", d_out); end
        checks++;
    endtask

    task automatic test_stop_err();
        int t0, p0, f0;
        t0 = tick_cnt; p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'h1C, 1'b0, 1'b0, -1);
        if (ferr_cnt - f0 !== 1) begin failures++; $display("FAIL stop_flag: got %0d expected 1", ferr_cnt - f0); end
        checks++;
        if (tick_cnt - t0 !== 0 || perr_cnt - p0 !== 0) begin
            failures++; $display("FAIL stop_other: got tick=%0d perr=%0d expected 0 0", tick_cnt - t0, perr_cnt - p0);
        end
        checks++;
    endtask

    task automatic test_glitch();
        int t0, p0, f0;
        t0 = tick_cnt; p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 3);
        if (tick_cnt - t0 !== 1 || d_out !== 8'h1C) begin
            failures++; $display("FAIL glitch_rx: got tick=%0d d_out=%h expected 1 1c", tick_cnt - t0, d_out);
        end
        checks++;
        if (perr_cnt - p0 !== 0 || ferr_cnt - f0 !== 0) begin
            failures++; $display("FAIL glitch_errs: got perr=%0d ferr=%0d expected 0 0", perr_cnt - p0, ferr_cnt - f0);
        end
        checks++;
    endtask

    task automatic test_timeout();
        int t0, f0;
        logic [7:0] b;
        b  = 8'h5A;
        t0 = tick_cnt; f0 = ferr_cnt;
        @(negedge clk);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        if (busy !== 1'b1) begin failures++; $display("FAIL timeout_busy_mid: got %b expected 1", busy); end
        checks++;
        repeat (TO / 2) @(negedge clk);
        if (ferr_cnt - f0 !== 0 || busy !== 1'b1) begin
            failures++; $display("FAIL timeout_early: got ferr=%0d busy=%b expected 0 1", ferr_cnt - f0, busy);
        end
        checks++;
        repeat (TO) @(negedge clk);
        if (ferr_cnt - f0 !== 1) begin failures++; $display("FAIL timeout_flag: got %0d expected 1", ferr_cnt - f0); end
        checks++;
        if (busy !== 1'b0 || tick_cnt - t0 !== 0) begin
            failures++; $display("FAIL timeout_state: got busy=%b tick=%0d expected 0 0", busy, tick_cnt - t0);
        end
        checks++;
        send_frame(8'h5A, 1'b1, 1'b1, -1);
        if (tick_cnt - t0 !== 1 || d_out !== 8'h5A) begin
            failures++; $display("FAIL timeout_recover: got tick=%0d d_out=%h expected 1 5a", tick_cnt - t0, d_out);
        end
        checks++;
    endtask

    task automatic test_reset_midframe();
        int t0;
        logic [7:0] b;
        b = 8'h33;
        @(negedge clk);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        if (busy !== 1'b1 || d_out !== 8'h5A) begin
            failures++; $display("FAIL midreset_pre: got busy=%b d_out=%h expected 1 5a", busy, d_out);
        end
        checks++;
        #3;
        reset = 1'b0;
        #1;
        if (d_out !== 8'h00 || busy !== 1'b0) begin
            failures++; $display("FAIL midreset_now: got d_out=%h busy=%b expected 00 0", d_out, busy);
        end
        checks++;
        if (tick !== 1'b0 || parity_err !== 1'b0 || frame_err !== 1'b0) begin
            failures++; $display("FAIL midreset_pulses: got tick=%b perr=%b ferr=%b expected 0 0 0",
                                 tick, parity_err, frame_err);
        end
        checks++;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        t0 = tick_cnt;
        send_frame(8'hF0, 1'b1, 1'b1, -1);
        if (tick_cnt - t0 !== 1 || d_out !== 8'hF0) begin
            failures++; $display("FAIL midreset_recover: got tick=%0d d_out=%h expected 1 f0", tick_cnt - t0, d_out);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_back_to_back();
        test_parity();
        test_stop_err();
        test_glitch();
        test_timeout();
        test_reset_midframe();
        repeat (5) @(negedge clk);
        if (dout_bad !== 0) begin failures++; $display("FAIL d_out_without_tick: got %0d changes expected 0", dout_bad); end
        checks++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
